// File: rtl/mlp_layer_engine.sv
// Fully-connected layer engine: y[o] = act(sum_i W[o][i]*x[i] + b[o]) in Q.FRAC_BITS,
// LANES MACs per cycle, saturating accumulation, valid/ready result stream.
module mlp_layer_engine #(
  parameter int LANES     = 8,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 4,
  parameter int MAX_IN    = 4096,
  parameter int MAX_OUT   = 256,
  parameter int WT_DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_inputs,
  input  logic [15:0]       num_outputs,
  input  logic [1:0]        act_mode,
  input  logic              in_we,
  input  logic [15:0]       in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wt_we,
  input  logic [15:0]       wt_addr,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              bias_we,
  input  logic [15:0]       bias_addr,
  input  logic [DATA_W-1:0] bias_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_idx,
  output logic              out_last
);

  localparam int IN_AW  = (MAX_IN   > 1) ? $clog2(MAX_IN)   : 1;
  localparam int OUT_AW = (MAX_OUT  > 1) ? $clog2(MAX_OUT)  : 1;
  localparam int WT_AW  = (WT_DEPTH > 1) ? $clog2(WT_DEPTH) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] D_MAX   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] D_MIN   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_BIAS, S_MAC, S_DRAIN, S_ACT, S_OUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0] n_r, m_r, o_r;
  logic [1:0]  mode_r;
  logic [31:0] i_r, wt_base, n32, m32;
  logic        drain_2nd, cfg_bad, mac_last, last_neuron;

  logic signed [DATA_W-1:0] in_buf   [MAX_IN];
  logic signed [DATA_W-1:0] wt_buf   [WT_DEPTH];
  logic signed [DATA_W-1:0] bias_buf [MAX_OUT];

  logic [31:0]              lane_in_idx [LANES];
  logic [WT_AW-1:0]         lane_wt_idx [LANES];
  logic                     lane_en     [LANES];
  logic signed [DATA_W-1:0] rd_x [LANES];
  logic signed [DATA_W-1:0] rd_w [LANES];
  logic signed [PROD_W-1:0] prod [LANES];
  logic signed [SUM_W-1:0]  lane_sum, sum_r;
  logic signed [ACC_W-1:0]  acc_r, acc_sat, shifted, act_s;
  logic        [ACC_W:0]    acc_ext;
  logic        [DATA_W-1:0] act_data;

  assign n32         = {16'd0, n_r};
  assign m32         = {16'd0, m_r};
  assign cfg_bad     = (n_r == '0) || (n32 > 32'(MAX_IN)) || (m_r == '0) ||
                       (m32 > 32'(MAX_OUT)) || ((n32 * m32) > 32'(WT_DEPTH));
  assign mac_last    = (i_r + 32'(LANES)) >= n32;
  assign last_neuron = (o_r == (m_r - 16'd1));

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_OUT);
  assign out_idx   = o_r;
  assign out_last  = out_valid && last_neuron;

  // Host buffers: no reset, writes only while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (in_we && ({16'd0, in_addr} < 32'(MAX_IN)))
        in_buf[in_addr[IN_AW-1:0]] <= in_data;
      if (wt_we && ({16'd0, wt_addr} < 32'(WT_DEPTH)))
        wt_buf[wt_addr[WT_AW-1:0]] <= wt_data;
      if (bias_we && ({16'd0, bias_addr} < 32'(MAX_OUT)))
        bias_buf[bias_addr[OUT_AW-1:0]] <= bias_data;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in_idx[l] = i_r + l;
      lane_wt_idx[l] = WT_AW'(wt_base + i_r + l);
      lane_en[l]     = (state == S_MAC) && (lane_in_idx[l] < n32);
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod[l]  = PROD_W'(rd_x[l]) * PROD_W'(rd_w[l]);
      lane_sum = lane_sum + SUM_W'(prod[l]);
    end
  end

  // One guard bit on the accumulator add detects overflow; clip instead of wrapping.
  always_comb begin
    acc_ext = {acc_r[ACC_W-1], acc_r} + (ACC_W+1)'(sum_r);
    if (acc_ext[ACC_W] != acc_ext[ACC_W-1])
      acc_sat = acc_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      acc_sat = acc_ext[ACC_W-1:0];
  end

  always_comb begin
    shifted = acc_r >>> FRAC_BITS;
    act_s   = shifted;
    if (mode_r == 2'd2 && shifted[ACC_W-1])
      act_s = shifted >>> 3;
    else if (mode_r == 2'd1 && shifted[ACC_W-1])
      act_s = '0;
    if (act_s > D_MAX)
      act_data = D_MAX[DATA_W-1:0];
    else if (act_s < D_MIN)
      act_data = D_MIN[DATA_W-1:0];
    else
      act_data = act_s[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = cfg_bad ? S_DONE : S_BIAS;
      S_BIAS:  state_nxt = S_MAC;
      S_MAC:   if (mac_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_2nd) state_nxt = S_ACT;
      S_ACT:   state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = last_neuron ? S_DONE : S_BIAS;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reads masked outside MAC keep the read/sum pipeline zero, so MAC/DRAIN can add every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r       <= '0;
      m_r       <= '0;
      o_r       <= '0;
      mode_r    <= '0;
      i_r       <= '0;
      wt_base   <= '0;
      drain_2nd <= 1'b0;
      cfg_err   <= 1'b0;
      acc_r     <= '0;
      sum_r     <= '0;
      out_data  <= '0;
      rd_x      <= '{default: '0};
      rd_w      <= '{default: '0};
    end else begin
      sum_r <= lane_sum;
      for (int unsigned l = 0; l < LANES; l++) begin
        rd_x[l] <= lane_en[l] ? in_buf[lane_in_idx[l][IN_AW-1:0]] : '0;
        rd_w[l] <= lane_en[l] ? wt_buf[lane_wt_idx[l]] : '0;
      end
      case (state)
        S_IDLE: if (start) begin
          n_r     <= num_inputs;
          m_r     <= num_outputs;
          mode_r  <= act_mode;
          cfg_err <= 1'b0;
        end
        S_CHECK: begin
          cfg_err <= cfg_bad;
          o_r     <= '0;
          wt_base <= '0;
        end
        S_BIAS: begin
          acc_r     <= ACC_W'(bias_buf[o_r[OUT_AW-1:0]]) <<< FRAC_BITS;
          i_r       <= '0;
          drain_2nd <= 1'b0;
        end
        S_MAC: begin
          acc_r <= acc_sat;
          i_r   <= i_r + 32'(LANES);
        end
        S_DRAIN: begin
          acc_r     <= acc_sat;
          drain_2nd <= 1'b1;
        end
        S_ACT: out_data <= act_data;
        S_OUT: if (out_ready && !last_neuron) begin
          o_r     <= o_r + 16'd1;
          wt_base <= wt_base + n32;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Directed self-checking bench for mlp_layer_engine (LANES=8, Q4.4 data).
module tb_mlp_layer_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_inputs = '0, num_outputs = '0;
  logic [1:0]  act_mode = '0;
  logic        in_we = 1'b0, wt_we = 1'b0, bias_we = 1'b0;
  logic [15:0] in_addr = '0, wt_addr = '0, bias_addr = '0;
  logic [7:0]  in_data = '0, wt_data = '0, bias_data = '0;
  logic        busy, done, cfg_err, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [15:0] out_idx;

  int tests = 0;
  int fails = 0;

  logic [7:0]  got_data [16];
  logic        got_last [16];
  int          got_n;
  bit          got_done, got_cfg;

  mlp_layer_engine #(
    .LANES(8), .DATA_W(8), .ACC_W(24), .FRAC_BITS(4),
    .MAX_IN(4096), .MAX_OUT(256), .WT_DEPTH(16384)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_inputs(num_inputs), .num_outputs(num_outputs), .act_mode(act_mode),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_in(input int a, input logic [7:0] d);
    in_addr = 16'(a); in_data = d; in_we = 1'b1;
    tick();
    in_we = 1'b0;
  endtask

  task automatic wr_wt(input int a, input logic [7:0] d);
    wt_addr = 16'(a); wt_data = d; wt_we = 1'b1;
    tick();
    wt_we = 1'b0;
  endtask

  task automatic wr_bias(input int a, input logic [7:0] d);
    bias_addr = 16'(a); bias_data = d; bias_we = 1'b1;
    tick();
    bias_we = 1'b0;
  endtask

  task automatic start_layer(input int n, input int m, input logic [1:0] mode);
    num_inputs = 16'(n); num_outputs = 16'(m); act_mode = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a layer with out_ready high, recording results; returns with the engine back in IDLE.
  task automatic drain_layer(input int n, input int m, input logic [1:0] mode);
    start_layer(n, m, mode);
    out_ready = 1'b1;
    got_n = 0; got_done = 1'b0; got_cfg = 1'b0;
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      if (out_valid && got_n < 16) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_n++;
      end
      if (done) begin
        got_done = 1'b1;
        got_cfg  = cfg_err;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, cfg_err, out_valid, out_last} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b exp 00000", {busy, done, cfg_err, out_valid, out_last});
    end
    tests++;
    if (out_data !== 8'h00 || out_idx !== 16'h0) begin
      fails++;
      $display("FAIL reset_data got data=%h idx=%0d exp 00/0", out_data, out_idx);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    for (int i = 0; i < 16; i++) begin
      wr_in(i, 8'h10);
      wr_wt(i, 8'h10);
      wr_wt(16 + i, 8'hF0);
    end
    wr_bias(0, 8'h00);
    wr_bias(1, 8'h00);
    out_ready = 1'b1;
    start_layer(16, 2, 2'd1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy); end
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    tests++;
    if (cyc !== 7) begin fails++; $display("FAIL basic_first_latency got %0d exp 7", cyc); end
    tests++;
    if (out_data !== 8'h7F || out_idx !== 16'd0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL basic_row0 got data=%h idx=%0d last=%b exp 7f/0/0", out_data, out_idx, out_last);
    end
    tick();
    cyc = 1;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    tests++;
    if (cyc !== 7) begin fails++; $display("FAIL basic_period got %0d exp 7", cyc); end
    tests++;
    if (out_data !== 8'h00 || out_idx !== 16'd1 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL basic_row1 got data=%h idx=%0d last=%b exp 00/1/1", out_data, out_idx, out_last);
    end
    tick();
    tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_done got done=%b busy=%b exp 1/1", done, busy);
    end
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_partial();
    int cyc;
    wr_in(0, 8'h10); wr_in(1, 8'h20); wr_in(2, 8'h08);
    for (int i = 0; i < 3; i++) wr_wt(i, 8'h10);
    wr_bias(0, 8'h08);
    start_layer(3, 1, 2'd0);
    wr_in(0, 8'h70);
    cyc = 1;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    tests++;
    if (cyc !== 6) begin fails++; $display("FAIL partial_latency got %0d exp 6", cyc); end
    tests++;
    if (out_data !== 8'h40 || out_last !== 1'b1) begin
      fails++;
      $display("FAIL partial_data got data=%h last=%b exp 40/1", out_data, out_last);
    end
    tick();
    tick();
    drain_layer(3, 1, 2'd0);
    tests++;
    if (got_n !== 1 || got_data[0] !== 8'h40) begin
      fails++;
      $display("FAIL partial_busy_write got n=%0d data=%h exp 1/40", got_n, got_data[0]);
    end
  endtask

  task automatic test_leaky();
    logic [1:0] modes [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [7:0] exps  [4] = '{8'hF8, 8'h00, 8'hC0, 8'hC0};
    wr_in(0, 8'h10);
    wr_wt(0, 8'hC0);
    wr_bias(0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      drain_layer(1, 1, modes[k]);
      tests++;
      if (got_n !== 1 || got_data[0] !== exps[k]) begin
        fails++;
        $display("FAIL act_mode%0d got n=%0d data=%h exp 1/%h", modes[k], got_n, got_data[0], exps[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    bit prev_valid;
    logic [7:0]  prev_data, exp_d;
    logic [15:0] prev_idx;
    wr_in(0, 8'h10);
    wr_in(1, 8'h10);
    for (int o = 0; o < 4; o++) begin
      wr_wt(2 * o, 8'(16 * (o + 1)));
      wr_wt(2 * o + 1, 8'h08);
      wr_bias(o, 8'h00);
    end
    start_layer(2, 4, 2'd0);
    hs = 0; prev_valid = 1'b0; prev_data = '0; prev_idx = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      out_ready = (cyc % 3 == 2);
      if (out_valid) begin
        if (prev_valid) begin
          tests++;
          if (out_data !== prev_data || out_idx !== prev_idx) begin
            fails++;
            $display("FAIL bp_stable got data=%h idx=%0d exp %h/%0d", out_data, out_idx, prev_data, prev_idx);
          end
        end
        if (out_ready) begin
          exp_d = 8'(16 * (hs + 1) + 8);
          tests++;
          if (out_idx !== 16'(hs) || out_data !== exp_d || out_last !== (hs == 3)) begin
            fails++;
            $display("FAIL bp_result got idx=%0d data=%h last=%b exp %0d/%h/%b",
                     out_idx, out_data, out_last, hs, exp_d, (hs == 3));
          end
          hs++;
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
          prev_data  = out_data;
          prev_idx   = out_idx;
        end
      end else begin
        prev_valid = 1'b0;
      end
      tick();
    end
    out_ready = 1'b1;
    tests++;
    if (hs !== 4 || done !== 1'b1) begin
      fails++;
      $display("FAIL bp_count got handshakes=%0d done=%b exp 4/1", hs, done);
    end
    tick();
  endtask

  task automatic test_config();
    int ns [2] = '{0, 200};
    int ms [2] = '{1, 100};
    for (int k = 0; k < 2; k++) begin
      start_layer(ns[k], ms[k], 2'd0);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || cfg_err !== 1'b0) begin
        fails++;
        $display("FAIL cfg%0d_check got busy=%b done=%b err=%b exp 1/0/0", k, busy, done, cfg_err);
      end
      tick();
      tests++;
      if (done !== 1'b1 || cfg_err !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL cfg%0d_done got done=%b err=%b valid=%b exp 1/1/0", k, done, cfg_err, out_valid);
      end
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL cfg%0d_sticky got busy=%b done=%b err=%b valid=%b exp 0/0/1/0",
                 k, busy, done, cfg_err, out_valid);
      end
    end
  endtask

  task automatic test_saturation_reset();
    int bad;
    for (int i = 0; i < 4096; i++) begin
      in_addr = 16'(i); in_data = 8'h7F; in_we = 1'b1;
      wt_addr = 16'(i); wt_data = 8'h7F; wt_we = 1'b1;
      tick();
    end
    in_we = 1'b0; wt_we = 1'b0;
    wr_bias(0, 8'h00);
    drain_layer(4096, 1, 2'd0);
    tests++;
    if (got_n !== 1 || got_data[0] !== 8'h7F || got_last[0] !== 1'b1 || got_cfg !== 1'b0) begin
      fails++;
      $display("FAIL sat_result got n=%0d data=%h last=%b err=%b exp 1/7f/1/0",
               got_n, got_data[0], got_last[0], got_cfg);
    end
    start_layer(4096, 1, 2'd0);
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL midrun_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({busy, done, cfg_err, out_valid, out_last} !== 5'b0 || out_data !== 8'h00 || out_idx !== 16'h0) begin
      fails++;
      $display("FAIL midrun_reset got flags=%b data=%h idx=%0d exp 00000/00/0",
               {busy, done, cfg_err, out_valid, out_last}, out_data, out_idx);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || out_valid || busy) bad++;
      tick();
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL midrun_quiet got %0d active cycles exp 0", bad); end
    drain_layer(4096, 1, 2'd0);
    tests++;
    if (got_n !== 1 || got_data[0] !== 8'h7F) begin
      fails++;
      $display("FAIL rerun_result got n=%0d data=%h exp 1/7f", got_n, got_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    int hs, dones, bad;
    wr_in(0, 8'h10);
    wr_wt(0, 8'hC0);
    wr_bias(0, 8'h00);
    out_ready = 1'b1;
    num_inputs = 16'd1; num_outputs = 16'd1; act_mode = 2'd0;
    start = 1'b1;
    hs = 0; dones = 0; bad = 0;
    for (int cyc = 0; cyc < 200 && dones < 2; cyc++) begin
      if (out_valid && out_ready) begin
        hs++;
        if (out_data !== 8'hC0) bad++;
      end
      if (done) dones++;
      if (dones == 2) start = 1'b0;
      tick();
    end
    start = 1'b0;
    tests++;
    if (hs !== 2 || dones !== 2 || bad !== 0) begin
      fails++;
      $display("FAIL b2b_count got handshakes=%0d dones=%0d bad=%0d exp 2/2/0", hs, dones, bad);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_leaky();
    test_backpressure();
    test_config();
    test_saturation_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
